// File: rtl/axil_master_bridge.sv
// AXI4-Lite master bridge: converts a single-outstanding CPU load/store port into
// AXI4-Lite write (AW/W/B) and read (AR/R) transactions, one at a time.
module axil_master_bridge #(
   parameter int         ADDR_WIDTH = 24,
   parameter int         DATA_WIDTH = 32,
   parameter int         STRB_WIDTH = DATA_WIDTH / 8,
   parameter logic [2:0] PROT       = 3'b000
) (
   input  logic                  clk,
   input  logic                  rst,
   // CPU request / response port
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_we,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [DATA_WIDTH-1:0] req_wdata,
   input  logic [STRB_WIDTH-1:0] req_wstrb,
   output logic                  resp_valid,
   input  logic                  resp_ready,
   output logic [DATA_WIDTH-1:0] resp_rdata,
   output logic                  resp_err,
   // AXI4-Lite write address channel
   output logic [ADDR_WIDTH-1:0] awaddr,
   output logic [2:0]            awprot,
   output logic                  awvalid,
   input  logic                  awready,
   // AXI4-Lite write data channel
   output logic [DATA_WIDTH-1:0] wdata,
   output logic [STRB_WIDTH-1:0] wstrb,
   output logic                  wvalid,
   input  logic                  wready,
   // AXI4-Lite write response channel
   input  logic [1:0]            bresp,
   input  logic                  bvalid,
   output logic                  bready,
   // AXI4-Lite read address channel
   output logic [ADDR_WIDTH-1:0] araddr,
   output logic [2:0]            arprot,
   output logic                  arvalid,
   input  logic                  arready,
   // AXI4-Lite read data channel
   input  logic [DATA_WIDTH-1:0] rdata,
   input  logic [1:0]            rresp,
   input  logic                  rvalid,
   output logic                  rready
);

   localparam logic [2:0] IDLE  = 3'd0;
   localparam logic [2:0] WRITE = 3'd1;
   localparam logic [2:0] WRESP = 3'd2;
   localparam logic [2:0] READ  = 3'd3;
   localparam logic [2:0] RRESP = 3'd4;
   localparam logic [2:0] RESP  = 3'd5;

   logic [2:0]            state;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [DATA_WIDTH-1:0] wdata_q;
   logic [STRB_WIDTH-1:0] wstrb_q;
   logic                  awvalid_q;
   logic                  wvalid_q;
   logic                  arvalid_q;
   logic [DATA_WIDTH-1:0] resp_rdata_q;
   logic                  resp_err_q;

   logic accept;
   logic write_done;
   logic unused_resp_bits;

   assign accept = (state == IDLE) && req_valid;

   // Each of AW/W counts as done if it already completed or completes this cycle.
   assign write_done = (!awvalid_q || awready) && (!wvalid_q || wready);

   // Only bit 1 of a response distinguishes SLVERR/DECERR from OKAY/EXOKAY.
   assign unused_resp_bits = bresp[0] ^ rresp[0];

   // NOTE: the request payload registers have no reset; they are only observed while a valid qualifies them.
   always_ff @(posedge clk) begin
      if (accept) begin
         addr_q  <= req_addr;
         wdata_q <= req_wdata;
         wstrb_q <= req_wstrb;
      end
   end

   // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state        <= IDLE;
         awvalid_q    <= 1'b0;
         wvalid_q     <= 1'b0;
         arvalid_q    <= 1'b0;
         resp_rdata_q <= '0;
         resp_err_q   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (req_valid) begin
                  if (req_we) begin
                     state     <= WRITE;
                     awvalid_q <= 1'b1;
                     wvalid_q  <= 1'b1;
                  end else begin
                     state     <= READ;
                     arvalid_q <= 1'b1;
                  end
               end
            end
            WRITE: begin
               if (awready) awvalid_q <= 1'b0;
               if (wready)  wvalid_q  <= 1'b0;
               if (write_done) state <= WRESP;
            end
            WRESP: begin
               if (bvalid) begin
                  resp_err_q   <= bresp[1];
                  resp_rdata_q <= '0;
                  state        <= RESP;
               end
            end
            READ: begin
               if (arready) begin
                  arvalid_q <= 1'b0;
                  state     <= RRESP;
               end
            end
            RRESP: begin
               if (rvalid) begin
                  resp_rdata_q <= rdata;
                  resp_err_q   <= rresp[1];
                  state        <= RESP;
               end
            end
            RESP: begin
               if (resp_ready) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign req_ready  = (state == IDLE);
   assign resp_valid = (state == RESP);
   assign resp_rdata = resp_rdata_q;
   assign resp_err   = resp_err_q;

   assign awaddr  = addr_q;
   assign awprot  = PROT;
   assign awvalid = awvalid_q;
   assign wdata   = wdata_q;
   assign wstrb   = wstrb_q;
   assign wvalid  = wvalid_q;
   assign bready  = (state == WRESP);
   assign araddr  = addr_q;
   assign arprot  = PROT;
   assign arvalid = arvalid_q;
   assign rready  = (state == RRESP);

endmodule

// File: tb/tb_axil_master_bridge.sv
// Self-checking bench for axil_master_bridge: a reactive AXI4-Lite slave model with
// programmable stalls/responses, and a scoreboard of expected CPU responses.
module tb_axil_master_bridge;

   localparam int AW = 24;
   localparam int DW = 32;
   localparam int SW = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          req_valid, req_ready, req_we;
   logic [AW-1:0] req_addr;
   logic [DW-1:0] req_wdata;
   logic [SW-1:0] req_wstrb;
   logic          resp_valid, resp_ready, resp_err;
   logic [DW-1:0] resp_rdata;
   logic [AW-1:0] awaddr, araddr;
   logic [2:0]    awprot, arprot;
   logic          awvalid, awready, wvalid, wready, bvalid, bready;
   logic          arvalid, arready, rvalid, rready;
   logic [DW-1:0] wdata, rdata;
   logic [SW-1:0] wstrb;
   logic [1:0]    bresp, rresp;

   always #5 clk = ~clk;

   axil_master_bridge #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
      .resp_valid(resp_valid), .resp_ready(resp_ready),
      .resp_rdata(resp_rdata), .resp_err(resp_err),
      .awaddr(awaddr), .awprot(awprot), .awvalid(awvalid), .awready(awready),
      .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
      .bresp(bresp), .bvalid(bvalid), .bready(bready),
      .araddr(araddr), .arprot(arprot), .arvalid(arvalid), .arready(arready),
      .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready)
   );

   typedef struct packed {
      logic [DW-1:0] rdata;
      logic          err;
   } exp_t;

   exp_t exp_q[$];
   int   errors = 0;
   int   checks = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // Slave configuration
   int            aw_delay, w_delay, ar_delay, b_delay, r_delay;
   logic [1:0]    bresp_cfg, rresp_cfg;
   logic [DW-1:0] rdata_cfg;

   // Slave state and observation
   bit            aw_got, w_got, ar_got, b_sent, r_sent;
   bit            aw_hs, w_hs, b_hs, ar_hs, r_hs;
   int            aw_wait, w_wait, ar_wait, b_wait, r_wait;
   int            aw_count = 0, w_count = 0, b_count = 0, ar_count = 0, r_count = 0;
   int            resp_count = 0;
   logic [AW-1:0] aw_addr_seen, ar_addr_seen;
   logic [DW-1:0] w_data_seen;
   logic [SW-1:0] w_strb_seen;

   task automatic slave_cfg(input int awd, input int wd, input int ard, input int bd, input int rd,
                            input logic [1:0] br, input logic [1:0] rr, input logic [DW-1:0] rdat);
      aw_delay = awd; w_delay = wd; ar_delay = ard; b_delay = bd; r_delay = rd;
      bresp_cfg = br; rresp_cfg = rr; rdata_cfg = rdat;
   endtask

   task automatic slave_clear();
      awready = 1'b0; wready = 1'b0; arready = 1'b0;
      bvalid = 1'b0; rvalid = 1'b0; bresp = 2'b00; rresp = 2'b00; rdata = '0;
      aw_got = 0; w_got = 0; ar_got = 0; b_sent = 0; r_sent = 0;
      aw_hs = 0; w_hs = 0; b_hs = 0; ar_hs = 0; r_hs = 0;
      aw_wait = 0; w_wait = 0; ar_wait = 0; b_wait = 0; r_wait = 0;
   endtask

   // Slave model: decides ready/valid at the falling edge; flagged handshakes complete at the next rising edge.
   initial begin
      slave_cfg(0, 0, 0, 0, 0, 2'b00, 2'b00, '0);
      slave_clear();
      forever begin
         @(negedge clk);
         if (!rst) begin
            slave_clear();
         end else begin
            if (aw_hs) begin aw_got = 1; aw_count++; end
            if (w_hs)  begin w_got = 1;  w_count++;  end
            if (ar_hs) begin ar_got = 1; ar_count++; end
            if (b_hs) begin
               bvalid = 1'b0; b_count++;
               aw_got = 0; w_got = 0; b_sent = 0; aw_wait = 0; w_wait = 0; b_wait = 0;
            end
            if (r_hs) begin
               rvalid = 1'b0; r_count++;
               ar_got = 0; r_sent = 0; ar_wait = 0; r_wait = 0;
            end
            awready = awvalid && !aw_got && (aw_wait >= aw_delay);
            if (awvalid && !aw_got) aw_wait++;
            wready = wvalid && !w_got && (w_wait >= w_delay);
            if (wvalid && !w_got) w_wait++;
            arready = arvalid && !ar_got && (ar_wait >= ar_delay);
            if (arvalid && !ar_got) ar_wait++;
            if (aw_got && w_got && !b_sent) begin
               if (b_wait >= b_delay) begin
                  bvalid = 1'b1; bresp = bresp_cfg; b_sent = 1;
               end else b_wait++;
            end
            if (ar_got && !r_sent) begin
               if (r_wait >= r_delay) begin
                  rvalid = 1'b1; rresp = rresp_cfg; rdata = rdata_cfg; r_sent = 1;
               end else r_wait++;
            end
            aw_hs = awvalid && awready;
            w_hs  = wvalid && wready;
            ar_hs = arvalid && arready;
            b_hs  = bvalid && bready;
            r_hs  = rvalid && rready;
            if (aw_hs) aw_addr_seen = awaddr;
            if (w_hs) begin w_data_seen = wdata; w_strb_seen = wstrb; end
            if (ar_hs) ar_addr_seen = araddr;
         end
      end
   end

   // Response monitor: pops the scoreboard on every response handshake.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst && resp_valid && resp_ready) begin
            resp_count++;
            if (exp_q.size() == 0) begin
               check("resp_unexpected", 1, 0);
            end else begin
               e = exp_q.pop_front();
               check("resp_rdata", resp_rdata, e.rdata);
               check("resp_err", resp_err, e.err);
            end
         end
      end
   end

   // Drives a request from just after a rising edge; returns just after the accept edge (T1).
   task automatic issue(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                        input logic [SW-1:0] strb, input logic [DW-1:0] exp_rdata, input logic exp_err);
      bit ok;
      exp_t e;
      ok = 0;
      req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = data; req_wstrb = strb;
      for (int n = 0; n < 50; n++) begin
         @(negedge clk);
         if (req_ready) begin ok = 1; break; end
      end
      check("req_accept_timeout", ok, 1);
      if (ok) begin
         e.rdata = exp_rdata; e.err = exp_err;
         exp_q.push_back(e);
      end
      @(posedge clk); #1;
      req_valid = 1'b0;
   endtask

   task automatic wait_done(input string tag);
      bit ok;
      ok = 0;
      for (int n = 0; n < 100; n++) begin
         @(negedge clk);
         if (exp_q.size() == 0 && req_ready) begin ok = 1; break; end
      end
      check(tag, ok, 1);
      @(posedge clk); #1;
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
      $fatal(1, "watchdog");
   end

   initial begin
      int b0, r0, aw0, w0;
      bit found;
      logic we;
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
      logic [SW-1:0] strb;
      logic [1:0] rsp;

      req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; req_wstrb = '0;
      resp_ready = 1'b1;
      rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_req_ready", req_ready, 1);
      check("rst_valids", {awvalid, wvalid, arvalid, bready, rready, resp_valid}, 6'b0);
      check("rst_resp_err", resp_err, 0);
      check("rst_resp_rdata", resp_rdata, 0);
      rst = 1'b1;
      @(posedge clk); #1;

      // 1: zero-wait write, latency T0..T3
      slave_cfg(0, 0, 0, 0, 0, 2'b00, 2'b00, '0);
      b0 = b_count;
      issue(1'b1, 24'h010000, 32'hDEADBEEF, 4'hF, 32'h0, 1'b0);
      @(negedge clk);
      check("t1_awvalid", awvalid, 1);
      check("t1_awaddr", awaddr, 24'h010000);
      check("t1_wvalid", wvalid, 1);
      check("t1_wdata", wdata, 32'hDEADBEEF);
      check("t1_wstrb", wstrb, 4'hF);
      check("t1_awprot", awprot, 3'b000);
      @(negedge clk);
      check("t1_t2_bready", bready, 1);
      check("t1_t2_resp_valid", resp_valid, 0);
      @(negedge clk);
      check("t1_t3_resp_valid", resp_valid, 1);
      wait_done("t1_done");
      check("t1_b_count", b_count - b0, 1);

      // 2: awready delayed 3 cycles, wready immediate
      slave_cfg(3, 0, 0, 0, 0, 2'b00, 2'b00, '0);
      b0 = b_count; r0 = resp_count; aw0 = aw_count; w0 = w_count;
      issue(1'b1, 24'h000010, 32'h0BEE5AFE, 4'h3, 32'h0, 1'b0);
      @(negedge clk);
      check("t2_t1_awvalid", awvalid, 1);
      check("t2_t1_wvalid", wvalid, 1);
      for (int c = 2; c <= 4; c++) begin
         @(negedge clk);
         check("t2_wvalid_low", wvalid, 0);
         check("t2_awvalid_held", awvalid, 1);
         check("t2_awaddr_stable", awaddr, 24'h000010);
      end
      @(negedge clk);
      check("t2_t5_awvalid", awvalid, 0);
      wait_done("t2_done");
      check("t2_aw_count", aw_count - aw0, 1);
      check("t2_w_count", w_count - w0, 1);
      check("t2_b_count", b_count - b0, 1);
      check("t2_resp_count", resp_count - r0, 1);
      check("t2_wstrb_seen", w_strb_seen, 4'h3);

      // 3: read with arready stalled 2 cycles
      slave_cfg(0, 0, 2, 0, 0, 2'b00, 2'b00, 32'h12345678);
      issue(1'b0, 24'h000004, 32'h0, 4'h0, 32'h12345678, 1'b0);
      for (int c = 1; c <= 3; c++) begin
         @(negedge clk);
         check("t3_arvalid_held", arvalid, 1);
         check("t3_araddr_stable", araddr, 24'h000004);
         check("t3_no_write", {awvalid, wvalid}, 2'b00);
      end
      @(negedge clk);
      check("t3_arvalid_drop", arvalid, 0);
      wait_done("t3_done");

      // 4: error responses then clean responses
      slave_cfg(0, 0, 0, 0, 0, 2'b11, 2'b00, 32'hCAFEF00D);
      issue(1'b1, 24'h000008, 32'h55AA55AA, 4'hF, 32'h0, 1'b1);
      wait_done("t4_decerr_done");
      issue(1'b0, 24'h000008, 32'h0, 4'h0, 32'hCAFEF00D, 1'b0);
      wait_done("t4_read_ok_done");
      slave_cfg(0, 0, 0, 1, 1, 2'b10, 2'b10, 32'h87654321);
      issue(1'b0, 24'h01000C, 32'h0, 4'h0, 32'h87654321, 1'b1);
      wait_done("t4_read_slverr_done");
      issue(1'b1, 24'h01000C, 32'h13579BDF, 4'h8, 32'h0, 1'b1);
      wait_done("t4_write_slverr_done");
      slave_cfg(0, 0, 0, 0, 0, 2'b01, 2'b01, 32'h00C0FFEE);
      issue(1'b0, 24'h000000, 32'h0, 4'h0, 32'h00C0FFEE, 1'b0);
      wait_done("t4_read_exokay_done");

      // 5: response back-pressure with a second request waiting
      slave_cfg(0, 0, 0, 0, 0, 2'b00, 2'b00, 32'hA5A50F0F);
      resp_ready = 1'b0;
      issue(1'b0, 24'h000010, 32'h0, 4'h0, 32'hA5A50F0F, 1'b0);
      req_valid = 1'b1; req_we = 1'b1; req_addr = 24'h010004; req_wdata = 32'h11112222; req_wstrb = 4'hF;
      found = 0;
      for (int n = 0; n < 20; n++) begin
         @(negedge clk);
         if (resp_valid) begin found = 1; break; end
      end
      check("t5_resp_valid_seen", found, 1);
      for (int c = 0; c < 5; c++) begin
         check("t5_resp_valid_hold", resp_valid, 1);
         check("t5_resp_rdata_hold", resp_rdata, 32'hA5A50F0F);
         check("t5_resp_err_hold", resp_err, 0);
         check("t5_req_ready_low", req_ready, 0);
         @(negedge clk);
      end
      @(posedge clk); #1;
      resp_ready = 1'b1;
      @(negedge clk);
      check("t5_req_ready_in_resp", req_ready, 0);
      @(negedge clk);
      check("t5_second_accept", req_ready, 1);
      if (req_ready) exp_q.push_back('{rdata: 32'h0, err: 1'b0});
      @(posedge clk); #1;
      req_valid = 1'b0;
      @(negedge clk);
      check("t5_second_awaddr", awaddr, 24'h010004);
      wait_done("t5_done");

      // 6: reset asserted while waiting in WRESP
      slave_cfg(0, 0, 0, 3, 0, 2'b00, 2'b00, '0);
      issue(1'b1, 24'h010008, 32'hFEEDFACE, 4'hF, 32'h0, 1'b0);
      found = 0;
      for (int n = 0; n < 20; n++) begin
         if (bready) begin found = 1; break; end
         @(negedge clk);
      end
      check("t6_wresp_reached", found, 1);
      rst = 1'b0;
      @(posedge clk); #1;
      check("t6_valids", {awvalid, wvalid, arvalid, resp_valid}, 4'b0);
      check("t6_bready", bready, 0);
      check("t6_rready", rready, 0);
      check("t6_req_ready", req_ready, 1);
      exp_q.delete();
      @(negedge clk);
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;

      // unaligned read issued as-is after reset
      slave_cfg(0, 0, 0, 0, 0, 2'b00, 2'b00, 32'h0BADF00D);
      issue(1'b0, 24'h000003, 32'h0, 4'h0, 32'h0BADF00D, 1'b0);
      @(negedge clk);
      check("t6_unaligned_araddr", araddr, 24'h000003);
      wait_done("t6_post_reset_done");

      // randomized mix of reads and writes with random stalls and responses
      for (int i = 0; i < 8; i++) begin
         we   = 1'($urandom_range(0, 1));
         addr = AW'($urandom);
         data = $urandom;
         strb = 4'($urandom_range(1, 15));
         rsp  = 2'($urandom_range(0, 3));
         slave_cfg($urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 2),
                   $urandom_range(0, 2), $urandom_range(0, 2), rsp, rsp, $urandom);
         issue(we, addr, data, strb, we ? 32'h0 : rdata_cfg, rsp[1]);
         wait_done("rnd_done");
         if (we) begin
            check("rnd_awaddr", aw_addr_seen, addr);
            check("rnd_wdata", w_data_seen, data);
            check("rnd_wstrb", w_strb_seen, strb);
         end else begin
            check("rnd_araddr", ar_addr_seen, addr);
         end
      end

      check("scoreboard_empty", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
